// File: rtl/commit_update_merger_pkg.sv
`default_nettype none
// ============================================================================
//  commit_pkg : shared types for the commit-table ack merger
//  Revision   : 1.0
// ============================================================================
package commit_pkg;

  localparam int CTA_SLOTS  = 4;
  localparam int EB_W       = $clog2(CTA_SLOTS + 4);
  localparam int CNT_W      = 4;
  localparam int MAX_REDUCE = 8;

  typedef struct packed {
    logic [EB_W-1:0]  eb;
    logic [CNT_W-1:0] cnt;
  } ack_entry_t;

  typedef enum logic {
    SRC_RD = 1'b0,
    SRC_WR = 1'b1
  } src_e;

endpackage
`default_nettype wire

// File: rtl/commit_update_merger_fifo.sv
`default_nettype none
// ============================================================================
//  ack_merge_fifo : per-source ack FIFO that folds same-e-block acks into its tail
//  Revision       : 1.0
// ============================================================================
module ack_merge_fifo
  import commit_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int EBW        = commit_pkg::EB_W,
  parameter int MAX_REDUCE = commit_pkg::MAX_REDUCE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [EBW-1:0]   in_eb,
  input  logic [3:0]       in_cnt,
  output logic             in_ready,
  output logic             head_valid,
  output ack_entry_t       head_entry,
  input  logic             pop
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int EW = $bits(ack_entry_t) - CNT_W;

  ack_entry_t    mem_q [DEPTH];
  ack_entry_t    mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;

  logic [PW-1:0] tail_ptr;
  ack_entry_t    tail_entry;
  ack_entry_t    in_entry;
  logic [4:0]    sum;
  logic          empty, full, pop_eff, last_popped, merge_ok;
  logic          do_merge, do_push;

  always_comb begin
    empty       = (occ_q == '0);
    full        = (occ_q == OW'(DEPTH));
    pop_eff     = pop && !empty;
    tail_ptr    = wr_ptr_q - PW'(1);
    tail_entry  = mem_q[tail_ptr];
    in_entry.eb  = EW'(in_eb);
    in_entry.cnt = in_cnt;
    sum         = 5'(tail_entry.cnt) + 5'(in_cnt);
    // A lone entry leaving this edge cannot absorb the incoming ack.
    last_popped = pop_eff && (occ_q == OW'(1));
    merge_ok    = !empty && (tail_entry.eb == in_entry.eb) &&
                  (sum <= 5'(MAX_REDUCE)) && !last_popped;
    in_ready    = merge_ok || !full || pop_eff;
    do_merge    = in_valid && in_ready && merge_ok;
    do_push     = in_valid && in_ready && !merge_ok;

    head_valid  = !empty;
    head_entry  = mem_q[rd_ptr_q];

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (do_merge) begin
      mem_d[tail_ptr].cnt = sum[3:0];
    end
    if (do_push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !pop_eff) begin
      occ_d = occ_q + OW'(1);
    end else if (!do_push && pop_eff) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/commit_update_merger.sv
`default_nettype none
// ============================================================================
//  commit_update_merger : merges LSU read/write acks per e-block and arbitrates
//                         them onto the commit table's single update port
//  Revision             : 1.0
// ============================================================================
module commit_update_merger
  import commit_pkg::*;
#(
  parameter int MAX_NUM_CTA  = commit_pkg::CTA_SLOTS,
  parameter int MAX_EBLOCK   = MAX_NUM_CTA + 4,
  parameter int DEPTH        = 4,
  parameter int MAX_REDUCE   = commit_pkg::MAX_REDUCE,
  localparam int EBW         = $clog2(MAX_EBLOCK)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rd_ack_valid,
  input  logic [EBW-1:0] rd_ack_e_block_id,
  input  logic [3:0]     rd_ack_count,
  output logic           rd_ack_ready,
  input  logic           wr_ack_valid,
  input  logic [EBW-1:0] wr_ack_e_block_id,
  input  logic [3:0]     wr_ack_count,
  output logic           wr_ack_ready,
  output logic           update_valid,
  output logic [EBW-1:0] update_e_block_id,
  output logic           update_is_write,
  output logic [3:0]     update_reduce_count,
  output logic           busy
);

  logic       rd_head_valid, wr_head_valid;
  ack_entry_t rd_head, wr_head, sel_head;
  logic       grant_rd, grant_wr;
  src_e       rr_pri_q, rr_pri_d;

  ack_merge_fifo #(
    .DEPTH      (DEPTH),
    .EBW        (EBW),
    .MAX_REDUCE (MAX_REDUCE)
  ) u_rd_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (rd_ack_valid),
    .in_eb      (rd_ack_e_block_id),
    .in_cnt     (rd_ack_count),
    .in_ready   (rd_ack_ready),
    .head_valid (rd_head_valid),
    .head_entry (rd_head),
    .pop        (grant_rd)
  );

  ack_merge_fifo #(
    .DEPTH      (DEPTH),
    .EBW        (EBW),
    .MAX_REDUCE (MAX_REDUCE)
  ) u_wr_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (wr_ack_valid),
    .in_eb      (wr_ack_e_block_id),
    .in_cnt     (wr_ack_count),
    .in_ready   (wr_ack_ready),
    .head_valid (wr_head_valid),
    .head_entry (wr_head),
    .pop        (grant_wr)
  );

  // Round-robin priority only moves when both heads compete.
  always_comb begin
    grant_rd = rd_head_valid && (!wr_head_valid || (rr_pri_q == SRC_RD));
    grant_wr = wr_head_valid && !grant_rd;
    rr_pri_d = rr_pri_q;
    if (rd_head_valid && wr_head_valid) begin
      rr_pri_d = grant_rd ? SRC_WR : SRC_RD;
    end

    sel_head            = grant_wr ? wr_head : rd_head;
    update_valid        = grant_rd || grant_wr;
    update_is_write     = grant_wr;
    update_e_block_id   = update_valid ? EBW'(sel_head.eb) : '0;
    update_reduce_count = update_valid ? sel_head.cnt : '0;
    busy                = rd_head_valid || wr_head_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_pri_q <= SRC_RD;
    end else begin
      rr_pri_q <= rr_pri_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && rd_ack_valid && rd_ack_ready) begin
      assert (rd_ack_count != 4'd0 && int'(rd_ack_count) <= MAX_REDUCE &&
              int'(rd_ack_e_block_id) < MAX_EBLOCK)
        else $error("rd ack out of range: eb=%0d count=%0d", rd_ack_e_block_id, rd_ack_count);
    end
    if (rst_n && wr_ack_valid && wr_ack_ready) begin
      assert (wr_ack_count != 4'd0 && int'(wr_ack_count) <= MAX_REDUCE &&
              int'(wr_ack_e_block_id) < MAX_EBLOCK)
        else $error("wr ack out of range: eb=%0d count=%0d", wr_ack_e_block_id, wr_ack_count);
    end
  end

endmodule
`default_nettype wire
